alu: RTL and testbench



---
 rtl/alu.sv | 58 +++++
 tb/tb_alu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit registered ALU for the accumulator computer: opcode IN_IR[15:12], one result per clock.
// Optional multiply/divide hardware is enabled by defining ALU_MULDIV_EN; otherwise opcodes 0x2/0x3 yield 0.
module alu (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] Q_AC,
  input  logic [15:0] Q_DR,
  input  logic [15:0] IN_IR,
  output logic [15:0] ALU_Result
);

  logic [3:0]  w_op;
  logic [15:0] w_mul;
  logic [15:0] w_div;
  logic [15:0] w_next;
  logic        w_unused_ir;

  assign w_op        = IN_IR[15:12];
  assign w_unused_ir = &{1'b0, IN_IR[11:0]};

`ifdef ALU_MULDIV_EN
  assign w_mul = Q_AC * Q_DR;
  // Divide-by-zero saturates to all ones rather than trapping.
  assign w_div = (Q_DR == 16'h0000) ? 16'hFFFF : (Q_AC / Q_DR);
`else
  assign w_mul = 16'h0000;
  assign w_div = 16'h0000;
`endif

  always_comb begin
    w_next = 16'h0000;
    case (w_op)
      4'h0: w_next = Q_AC + Q_DR;
      4'h1: w_next = Q_AC - Q_DR;
      4'h2: w_next = w_mul;
      4'h3: w_next = w_div;
      4'h4: w_next = {Q_AC[14:0], 1'b0};
      4'h5: w_next = {1'b0, Q_AC[15:1]};
      4'h6: w_next = {Q_AC[14:0], Q_AC[15]};
      4'h7: w_next = {Q_AC[0], Q_AC[15:1]};
      4'h8: w_next = Q_AC & Q_DR;
      4'h9: w_next = Q_AC | Q_DR;
      4'hA: w_next = Q_AC ^ Q_DR;
      4'hB: w_next = ~(Q_AC | Q_DR);
      4'hC: w_next = ~(Q_AC & Q_DR);
      4'hD: w_next = {15'd0, (Q_AC < Q_DR)};
      4'hE: w_next = {15'd0, (Q_AC > Q_DR)};
      4'hF: w_next = {15'd0, (Q_AC == Q_DR)};
      default: w_next = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ALU_Result <= 16'h0000;
    else        ALU_Result <= w_next;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model compared every cycle, plus literal vectors.
// Expectations for opcodes 0x2/0x3 follow whether ALU_MULDIV_EN is defined for the build.
module tb_alu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] Q_AC, Q_DR, IN_IR;
  logic [15:0] ALU_Result;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          chk_en = 1'b0;
  logic [15:0] exp_q  = 16'h0000;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  alu dut (
    .CLK(CLK), .RST_N(RST_N), .Q_AC(Q_AC), .Q_DR(Q_DR),
    .IN_IR(IN_IR), .ALU_Result(ALU_Result)
  );

  always #5 CLK = ~CLK;

  // Reference written as plain integer arithmetic on the opcode definitions.
  function automatic logic [15:0] model(input logic [15:0] ac, input logic [15:0] dr,
                                        input logic [15:0] ir);
    int unsigned a, b, r;
    a = ac; b = dr; r = 0;
    case (ir / 4096)
      0:  r = (a + b) % 65536;
      1:  r = (a + 65536 - b) % 65536;
      2:  r = MULDIV ? ((a * b) % 65536) : 0;
      3:  r = MULDIV ? ((b == 0) ? 65535 : a / b) : 0;
      4:  r = (a * 2) % 65536;
      5:  r = a / 2;
      6:  r = (a * 2) % 65536 + a / 32768;
      7:  r = a / 2 + (a % 2) * 32768;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 65535 - (a | b);
      12: r = 65535 - (a & b);
      13: r = (a < b) ? 1 : 0;
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return r[15:0];
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) exp_q <= 16'h0000;
    else        exp_q <= model(Q_AC, Q_DR, IN_IR);
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      n_cmp++;
      if (ALU_Result !== exp_q) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t ac=%h dr=%h ir=%h got=%h want=%h",
                 $time, Q_AC, Q_DR, IN_IR, ALU_Result, exp_q);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] want);
    n_cmp++;
    if (ALU_Result !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, ALU_Result, want);
    end
  endtask

  task automatic apply(input string name, input logic [15:0] ac, input logic [15:0] dr,
                       input logic [15:0] ir, input logic [15:0] want);
    Q_AC = ac; Q_DR = dr; IN_IR = ir;
    @(posedge CLK); #1;
    check(name, want);
  endtask

  initial begin
    RST_N = 1'b1; Q_AC = 16'h0002; Q_DR = 16'h0003; IN_IR = 16'h0000;
    #2 RST_N = 1'b0;
    chk_en = 1'b1;
    #1 check("reset_initial", 16'h0000);
    @(posedge CLK); #1 check("reset_held_initial", 16'h0000);
    #2 RST_N = 1'b1;

    apply("add",  16'h0002, 16'h0003, 16'h0000, 16'h0005);
    apply("sub",  16'h0002, 16'h0003, 16'h1000, 16'hFFFF);
    apply("mul",  16'h0002, 16'h0003, 16'h2000, MULDIV ? 16'h0006 : 16'h0000);
    apply("div",  16'h0002, 16'h0003, 16'h3000, 16'h0000);
    apply("shl",  16'h0002, 16'h0003, 16'h4000, 16'h0004);
    apply("shr",  16'h0002, 16'h0003, 16'h5000, 16'h0001);
    apply("rol",  16'h0002, 16'h0003, 16'h6000, 16'h0004);
    apply("ror",  16'h0002, 16'h0003, 16'h7000, 16'h0001);
    apply("rol_wrap", 16'h8001, 16'h0003, 16'h6000, 16'h0003);
    apply("ror_wrap", 16'h8001, 16'h0003, 16'h7000, 16'hC000);
    apply("and",  16'h0002, 16'h0003, 16'h8000, 16'h0002);
    apply("or",   16'h0002, 16'h0003, 16'h9000, 16'h0003);
    apply("xor",  16'h0002, 16'h0003, 16'hA000, 16'h0001);
    apply("nor",  16'h0002, 16'h0003, 16'hB000, 16'hFFFC);
    apply("nand", 16'h0002, 16'h0003, 16'hC000, 16'hFFFD);
    apply("lt",   16'h0002, 16'h0003, 16'hD000, 16'h0001);
    apply("gt",   16'h0002, 16'h0003, 16'hE000, 16'h0000);
    apply("eq_ne",16'h0002, 16'h0003, 16'hF000, 16'h0000);
    apply("eq",   16'h1234, 16'h1234, 16'hF000, 16'h0001);
    apply("gt_true", 16'h0004, 16'h0003, 16'hEABC, 16'h0001);
    apply("add_wrap", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000);
    apply("div_zero", 16'h0002, 16'h0000, 16'h3000, MULDIV ? 16'hFFFF : 16'h0000);
    apply("div_7",    16'h0064, 16'h0007, 16'h3FFF, MULDIV ? 16'h000E : 16'h0000);
    apply("mul_wrap", 16'h0100, 16'h0101, 16'h2000, MULDIV ? 16'h0100 : 16'h0000);
    apply("ir_low_ignored", 16'h0002, 16'h0003, 16'h0FFF, 16'h0005);

    // Input changes between edges must not reach the output.
    Q_AC = 16'h7777; IN_IR = 16'h9000; #3;
    check("hold_between_edges", 16'h0005);

    // Mid-stream reset: clears immediately and holds, released result on next edge.
    apply("pre_reset", 16'h0002, 16'h0003, 16'h0000, 16'h0005);
    #2 RST_N = 1'b0;
    #1 check("reset_async", 16'h0000);
    @(posedge CLK); #1 check("reset_held_1", 16'h0000);
    @(posedge CLK); #1 check("reset_held_2", 16'h0000);
    RST_N = 1'b1;
    #1 check("reset_release_before_edge", 16'h0000);
    @(posedge CLK); #1 check("reset_release_load", 16'h0005);

    for (int i = 0; i < 200; i++) begin
      Q_AC  = 16'($urandom);
      Q_DR  = (i % 9 == 0) ? 16'h0000 : 16'($urandom);
      IN_IR = 16'($urandom);
      @(posedge CLK); #1;
    end

    @(negedge CLK); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
